// File: rtl/hazard_ctrl_if.sv
// Hazard control bus: pipeline status flowing into the hazard controller and the
// pause/bubble controls flowing back out to the PC and pipeline registers.
interface hazard_ctrl_if;
   // Status from ID / EX / MEM stages
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_use_rs1;
   logic       id_use_rs2;
   logic [4:0] ex_rd;
   logic       ex_mem_read;
   logic       ex_div_start;
   logic       ex_branch_taken;
   logic       mem_req;
   logic       mem_ready;

   // Freeze / flush controls back to the pipeline
   logic       pc_pause;
   logic       pause_if_id;
   logic       bubble_if_id;
   logic       pause_id_ex;
   logic       bubble_id_ex;
   logic       pause_ex_mem;
   logic       bubble_ex_mem;
   logic       pause_mem_wb;
   logic       bubble_mem_wb;
   logic       div_busy;
   logic       mem_fault;

   // Pipeline side: reports stage status, obeys the controls
   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             ex_div_start, ex_branch_taken, mem_req, mem_ready,
      input  pc_pause, pause_if_id, bubble_if_id, pause_id_ex, bubble_id_ex,
             pause_ex_mem, bubble_ex_mem, pause_mem_wb, bubble_mem_wb,
             div_busy, mem_fault
   );

   // Hazard controller side
   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             ex_div_start, ex_branch_taken, mem_req, mem_ready,
      output pc_pause, pause_if_id, bubble_if_id, pause_id_ex, bubble_id_ex,
             pause_ex_mem, bubble_ex_mem, pause_mem_wb, bubble_mem_wb,
             div_busy, mem_fault
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: single source of pipeline freeze/flush decisions.
// Handles load-use stalls, taken-branch flushes, multi-cycle divide stalls and
// data-memory wait states with a timeout abort.
module hazard_ctrl #(
   parameter int DIV_CYCLES  = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic          clock,
   input  logic          reset_n,
   hazard_ctrl_if.slave  hz
);

   localparam int DW = $clog2(DIV_CYCLES) + 1;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_MWAIT = 2'd1;
   localparam logic [1:0] ST_DIV   = 2'd2;

   logic [1:0]    state, state_nxt;
   logic [7:0]    wcnt, wcnt_nxt;
   logic [DW-1:0] dcnt, dcnt_nxt;
   logic          fault_nxt;
   logic          load_use;

   // Load-use: a load in EX writes a register the ID instruction reads (x0 never hazards)
   assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                     ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                      (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

   // Next-state, counter updates and same-cycle pause/bubble controls
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      state_nxt        = state;
      wcnt_nxt         = wcnt;
      dcnt_nxt         = dcnt;
      fault_nxt        = 1'b0;
      hz.pc_pause      = 1'b0;
      hz.pause_if_id   = 1'b0;
      hz.bubble_if_id  = 1'b0;
      hz.pause_id_ex   = 1'b0;
      hz.bubble_id_ex  = 1'b0;
      hz.pause_ex_mem  = 1'b0;
      hz.bubble_ex_mem = 1'b0;
      hz.pause_mem_wb  = 1'b0;
      hz.bubble_mem_wb = 1'b0;
      hz.div_busy      = 1'b0;

      case (state)
         ST_RUN: begin
            if (hz.mem_req && !hz.mem_ready) begin
               // Memory not ready: freeze everything up to EX/MEM, bubble into WB
               hz.pc_pause      = 1'b1;
               hz.pause_if_id   = 1'b1;
               hz.pause_id_ex   = 1'b1;
               hz.pause_ex_mem  = 1'b1;
               hz.bubble_mem_wb = 1'b1;
               state_nxt        = ST_MWAIT;
               wcnt_nxt         = 8'd1;
            end else if (hz.ex_div_start) begin
               // Divide start cycle counts as the first of DIV_CYCLES stall cycles
               hz.pc_pause      = 1'b1;
               hz.pause_if_id   = 1'b1;
               hz.pause_id_ex   = 1'b1;
               hz.bubble_ex_mem = 1'b1;
               hz.div_busy      = 1'b1;
               state_nxt        = ST_DIV;
               dcnt_nxt         = DW'(DIV_CYCLES - 1);
            end else if (hz.ex_branch_taken) begin
               // Flush wrong-path instructions; any load-use in ID dies with them
               hz.bubble_if_id  = 1'b1;
               hz.bubble_id_ex  = 1'b1;
            end else if (load_use) begin
               hz.pc_pause      = 1'b1;
               hz.pause_if_id   = 1'b1;
               hz.bubble_id_ex  = 1'b1;
            end
         end

         ST_MWAIT: begin
            if (hz.mem_ready || !hz.mem_req) begin
               // Access completes: let MEM result flow on, no controls this cycle
               state_nxt = ST_RUN;
               wcnt_nxt  = 8'd0;
            end else if (wcnt == 8'(MEM_TIMEOUT)) begin
               // Give up on the access: drop it from WB and flag the abort next cycle
               hz.bubble_mem_wb = 1'b1;
               fault_nxt        = 1'b1;
               state_nxt        = ST_RUN;
               wcnt_nxt         = 8'd0;
            end else begin
               hz.pc_pause      = 1'b1;
               hz.pause_if_id   = 1'b1;
               hz.pause_id_ex   = 1'b1;
               hz.pause_ex_mem  = 1'b1;
               hz.bubble_mem_wb = 1'b1;
               wcnt_nxt         = (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
            end
         end

         ST_DIV: begin
            // div_busy tracks the stall cycles; the release cycle consumes the
            // still-present ex_div_start without retriggering, and mem_req is ignored
            if (dcnt != '0) begin
               hz.pc_pause      = 1'b1;
               hz.pause_if_id   = 1'b1;
               hz.pause_id_ex   = 1'b1;
               hz.bubble_ex_mem = 1'b1;
               hz.div_busy      = 1'b1;
               dcnt_nxt         = dcnt - DW'(1);
            end else begin
               state_nxt = ST_RUN;
            end
         end

         default: begin
            state_nxt = ST_RUN;
            wcnt_nxt  = 8'd0;
            dcnt_nxt  = '0;
         end
      endcase

      // While in reset the whole pipeline is flushed and nothing is held
      if (!reset_n) begin
         hz.pc_pause      = 1'b0;
         hz.pause_if_id   = 1'b0;
         hz.pause_id_ex   = 1'b0;
         hz.pause_ex_mem  = 1'b0;
         hz.pause_mem_wb  = 1'b0;
         hz.bubble_if_id  = 1'b1;
         hz.bubble_id_ex  = 1'b1;
         hz.bubble_ex_mem = 1'b1;
         hz.bubble_mem_wb = 1'b1;
         hz.div_busy      = 1'b0;
      end
   end

   // State, wait/divide counters and registered fault pulse
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_RUN;
         wcnt         <= 8'd0;
         dcnt         <= '0;
         hz.mem_fault <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers
         // update together from the values seen before the edge.
         state        <= state_nxt;
         wcnt         <= wcnt_nxt;
         dcnt         <= dcnt_nxt;
         hz.mem_fault <= fault_nxt;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table-driven single-cycle RUN checks plus
// hand-written multi-cycle sequences for divide, memory wait, timeout and reset.
module tb_hazard_ctrl;

   logic clock;
   logic reset_n;
   int   passed;
   int   total;

   hazard_ctrl_if hif ();

   hazard_ctrl #(.DIV_CYCLES(4), .MEM_TIMEOUT(8)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .hz      (hif.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Packed control view: pc_pause, pause_if_id, bubble_if_id, pause_id_ex, bubble_id_ex,
   // pause_ex_mem, bubble_ex_mem, pause_mem_wb, bubble_mem_wb, div_busy
   logic [9:0] outs;
   assign outs = {hif.pc_pause, hif.pause_if_id, hif.bubble_if_id, hif.pause_id_ex,
                  hif.bubble_id_ex, hif.pause_ex_mem, hif.bubble_ex_mem,
                  hif.pause_mem_wb, hif.bubble_mem_wb, hif.div_busy};

   localparam logic [9:0] C_NONE  = 10'b0000000000;
   localparam logic [9:0] C_MST   = 10'b1101010010;
   localparam logic [9:0] C_DST   = 10'b1101001001;
   localparam logic [9:0] C_LU    = 10'b1100100000;
   localparam logic [9:0] C_BR    = 10'b0010100000;
   localparam logic [9:0] C_RST   = 10'b0010101010;
   localparam logic [9:0] C_TOUT  = 10'b0000000010;

   typedef struct {
      string      name;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use1;
      logic       use2;
      logic [4:0] rd;
      logic       mrd;
      logic       br;
      logic       mreq;
      logic       mrdy;
      logic [9:0] exp;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %b expected %b", nm, act, exp);
   endtask

   // Compare controls (and mem_fault) at the falling edge, then move past the next rising edge
   task automatic cyc(input string nm, input logic [9:0] exp, input logic exp_fault);
      @(negedge clock);
      check(nm, outs, exp);
      check({nm, "_fault"}, {9'b0, hif.mem_fault}, {9'b0, exp_fault});
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      hif.id_rs1 = 5'd0;  hif.id_rs2 = 5'd0;
      hif.id_use_rs1 = 1'b0;  hif.id_use_rs2 = 1'b0;
      hif.ex_rd = 5'd0;  hif.ex_mem_read = 1'b0;
      hif.ex_div_start = 1'b0;  hif.ex_branch_taken = 1'b0;
      hif.mem_req = 1'b0;  hif.mem_ready = 1'b0;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      vecs[0] = '{"lu_rs2",      5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
      vecs[1] = '{"lu_rs1",      5'd7, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
      vecs[2] = '{"lu_rd0",      5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE};
      vecs[3] = '{"lu_unused",   5'd2, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE};
      vecs[4] = '{"not_load",    5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
      vecs[5] = '{"branch",      5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, C_BR};
      vecs[6] = '{"branch_lu",   5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_BR};
      vecs[7] = '{"mem_rdy_lu",  5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, C_LU};
      vecs[8] = '{"idle",        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};

      // Reset state
      idle_inputs();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_ctrl", outs, C_RST);
      check("reset_fault", {9'b0, hif.mem_fault}, 10'b0);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // T1/T5a: single-cycle RUN decisions
      for (int i = 0; i < 9; i++) begin
         hif.id_rs1 = vecs[i].rs1;  hif.id_rs2 = vecs[i].rs2;
         hif.id_use_rs1 = vecs[i].use1;  hif.id_use_rs2 = vecs[i].use2;
         hif.ex_rd = vecs[i].rd;  hif.ex_mem_read = vecs[i].mrd;
         hif.ex_branch_taken = vecs[i].br;
         hif.mem_req = vecs[i].mreq;  hif.mem_ready = vecs[i].mrdy;
         cyc(vecs[i].name, vecs[i].exp, 1'b0);
      end
      idle_inputs();

      // T2: divide, 4 stall cycles, release cycle ignores the held start
      hif.ex_div_start = 1'b1;
      hif.mem_req = 1'b1;  // ignored while dividing once started
      hif.mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) cyc($sformatf("div_stall%0d", i), C_DST, 1'b0);
      hif.mem_ready = 1'b0;
      cyc("div_release", C_NONE, 1'b0);
      idle_inputs();
      cyc("div_after", C_NONE, 1'b0);

      // T3 + T5b: memory wait 3 cycles with a pending branch, flush after release
      hif.mem_req = 1'b1;  hif.mem_ready = 1'b0;  hif.ex_branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) cyc($sformatf("mwait%0d", i), C_MST, 1'b0);
      hif.mem_ready = 1'b1;
      cyc("mwait_release", C_NONE, 1'b0);
      hif.mem_req = 1'b0;  hif.mem_ready = 1'b0;
      cyc("deferred_branch", C_BR, 1'b0);
      idle_inputs();

      // T4: timeout after 8 stall cycles, fault pulse one cycle after the abort
      hif.mem_req = 1'b1;
      for (int i = 0; i < 8; i++) cyc($sformatf("tout_stall%0d", i), C_MST, 1'b0);
      cyc("tout_abort", C_TOUT, 1'b0);
      hif.mem_req = 1'b0;
      cyc("tout_fault", C_NONE, 1'b1);
      cyc("tout_clear", C_NONE, 1'b0);

      // T6: reset in the middle of a divide
      hif.ex_div_start = 1'b1;
      cyc("div2_start", C_DST, 1'b0);
      cyc("div2_cnt3", C_DST, 1'b0);
      reset_n = 1'b0;
      #2;
      check("div_reset_ctrl", outs, C_RST);
      hif.ex_div_start = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      cyc("post_reset_run", C_NONE, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
